// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer, flush, and a
// saturating bubble counter. Payload and control are packed by the instantiator.
module pipe_stage_reg #(
   parameter int DATA_W   = 128,
   parameter int CTRL_W   = 12,
   parameter int SKID     = 1,
   parameter int NEG_EDGE = 1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } entry_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_t state, state_nx;
   entry_t main_q, skid_q;
   logic   eclk;
   logic   in_xfer, out_xfer;
   logic   load_main, load_skid, skid_to_main;

   // Single clock net for all state; falling-edge operation is an inversion.
   assign eclk = (NEG_EDGE != 0) ? ~clk : clk;

   assign out_valid = (state != EMPTY);
   assign out_data  = main_q.data;
   assign out_ctrl  = out_valid ? main_q.ctrl : '0;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   generate
      if (SKID != 0) begin : g_skid
         logic rdy_r;
         always_ff @(posedge eclk) begin
            if (!rst_n) rdy_r <= 1'b0;
            else        rdy_r <= (state_nx != TWO);
         end
         assign in_ready = rdy_r & ~flush;
      end else begin : g_noskid
         assign in_ready = (~out_valid | out_ready) & ~flush;
      end
   endgenerate

   always_comb begin
      state_nx     = state;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      if (flush) begin
         state_nx = EMPTY;
      end else begin
         case (state)
            EMPTY: if (in_xfer) begin
               state_nx  = ONE;
               load_main = 1'b1;
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  load_main = 1'b1;
               end else if (in_xfer) begin
                  state_nx  = TWO;
                  load_skid = 1'b1;
               end else if (out_xfer) begin
                  state_nx  = EMPTY;
               end
            end
            TWO: if (out_xfer) begin
               state_nx     = ONE;
               skid_to_main = 1'b1;
            end
            default: state_nx = EMPTY;
         endcase
      end
   end

   always_ff @(posedge eclk) begin
      if (!rst_n) begin
         state      <= EMPTY;
         bubble_cnt <= '0;
      end else begin
         state <= state_nx;
         if (!out_valid && !(&bubble_cnt))
            bubble_cnt <= bubble_cnt + CNT_ONE;
      end
   end

   // Payload registers carry no reset; validity alone lives in the state.
   always_ff @(posedge eclk) begin
      if (load_main)
         main_q <= '{ctrl: in_ctrl, data: in_data};
      else if (skid_to_main)
         main_q <= skid_q;
      if (load_skid)
         skid_q <= '{ctrl: in_ctrl, data: in_data};
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic, all cycles
// checked against a queue-based reference model of the stage.
module tb_pipe_stage_reg;
   localparam int DW   = 16;
   localparam int CW   = 8;
   localparam int MAXB = 15;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, out_ready;
   logic          in_ready, out_valid;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [3:0]    bubble_cnt;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] qd[$];
   logic [CW-1:0] qc[$];
   logic [DW-1:0] got[$];
   bit            rdy_m;
   int            bub_m;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .NEG_EDGE(1), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ctrl(out_ctrl), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle: check outputs against the model, then advance both at the falling edge.
   task automatic cyc(input bit r, input bit fl, input bit iv, input bit ordy,
                      input logic [DW-1:0] d, input logic [CW-1:0] c);
      bit ix, ox;
      rst_n = r; flush = fl; in_valid = iv; out_ready = ordy; in_data = d; in_ctrl = c;
      #1;
      chk("in_ready", 64'(in_ready), 64'(rdy_m & ~fl));
      chk("out_valid", 64'(out_valid), 64'(qd.size() > 0));
      chk("out_ctrl", 64'(out_ctrl), (qd.size() > 0) ? 64'(qc[0]) : 64'd0);
      if (qd.size() > 0) chk("out_data", 64'(out_data), 64'(qd[0]));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(bub_m));
      @(negedge clk);
      if (!r) begin
         qd.delete(); qc.delete();
         bub_m = 0;
         rdy_m = 1'b0;
      end else begin
         if (qd.size() == 0 && bub_m < MAXB) bub_m++;
         ix = iv & rdy_m & ~fl;
         ox = (qd.size() > 0) & ordy;
         if (ox) begin
            got.push_back(qd.pop_front());
            void'(qc.pop_front());
         end
         if (fl) begin
            qd.delete(); qc.delete();
         end else if (ix) begin
            qd.push_back(d); qc.push_back(c);
         end
         rdy_m = (qd.size() < 2);
      end
      @(posedge clk);
   endtask

   initial begin
      int nb;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_ctrl = '0;
      rdy_m = 1'b0; bub_m = 0;
      repeat (2) @(negedge clk);
      @(posedge clk);

      // reset state and single pass-through
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 16'h55, 8'h1);
      chk("rst_vld", 64'(out_valid), 64'd0);
      chk("rst_bub", 64'(bubble_cnt), 64'd0);
      chk("rst_rdy", 64'(in_ready), 64'd0);
      cyc(1, 0, 0, 1, 0, 0);
      got.delete();
      cyc(1, 0, 1, 1, 16'hA, 8'h3);
      chk("t1_vld", 64'(out_valid), 64'd1);
      chk("t1_data", 64'(out_data), 64'hA);
      chk("t1_ctrl", 64'(out_ctrl), 64'h3);
      cyc(1, 0, 0, 1, 0, 0);
      chk("t1_vld0", 64'(out_valid), 64'd0);
      chk("t1_ctrl0", 64'(out_ctrl), 64'd0);
      chk("t1_got", 64'(got.size()), 64'd1);

      // skid fill: third entry held upstream, then in-order drain
      got.delete();
      cyc(1, 0, 1, 0, 16'h1, 8'h11);
      cyc(1, 0, 1, 0, 16'h2, 8'h12);
      chk("skid_rdy0", 64'(in_ready), 64'd0);
      chk("skid_head", 64'(out_data), 64'h1);
      cyc(1, 0, 1, 0, 16'h3, 8'h13);
      cyc(1, 0, 1, 1, 16'h3, 8'h13);
      chk("skid_head2", 64'(out_data), 64'h2);
      cyc(1, 0, 1, 1, 16'h3, 8'h13);
      chk("skid_head3", 64'(out_data), 64'h3);
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      chk("skid_cnt", 64'(got.size()), 64'd3);
      if (got.size() == 3) begin
         chk("skid_o0", 64'(got[0]), 64'h1);
         chk("skid_o1", 64'(got[1]), 64'h2);
         chk("skid_o2", 64'(got[2]), 64'h3);
      end

      // flush from TWO with a simultaneous input
      got.delete();
      cyc(1, 0, 1, 0, 16'h5, 8'h25);
      cyc(1, 0, 1, 0, 16'h6, 8'h26);
      chk("fl_full", 64'(in_ready), 64'd0);
      cyc(1, 1, 1, 0, 16'h7, 8'h27);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("fl_vld", 64'(out_valid), 64'd0);
      chk("fl_ctrl", 64'(out_ctrl), 64'd0);
      chk("fl_rdy", 64'(in_ready), 64'd1);
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      chk("fl_got", 64'(got.size()), 64'd0);

      // 100-entry continuous stream right after reset
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      got.delete();
      for (int i = 0; i < 100; i++) cyc(1, 0, 1, 1, 16'(i), 8'(i ^ 8'h5A));
      cyc(1, 0, 0, 1, 0, 0);
      chk("str_cnt", 64'(got.size()), 64'd100);
      nb = 0;
      foreach (got[i]) if (got[i] !== 16'(i)) nb++;
      chk("str_order", 64'(nb), 64'd0);
      chk("str_bub", 64'(bubble_cnt), 64'd2);

      // random traffic with occasional flush and reset
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 15) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             16'($urandom), 8'($urandom));

      // bubble saturation and mid-stream reset
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 0);
      chk("sat_15", 64'(bubble_cnt), 64'd15);
      repeat (3) cyc(1, 0, 0, 0, 0, 0);
      chk("sat_hold", 64'(bubble_cnt), 64'd15);
      cyc(1, 0, 1, 0, 16'hB1, 8'h31);
      cyc(1, 0, 1, 0, 16'hB2, 8'h32);
      chk("mr_vld1", 64'(out_valid), 64'd1);
      cyc(0, 1, 1, 1, 16'hB3, 8'h33);
      chk("mr_vld0", 64'(out_valid), 64'd0);
      chk("mr_ctrl", 64'(out_ctrl), 64'd0);
      chk("mr_bub", 64'(bubble_cnt), 64'd0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
